// File: rtl/parity_stream_checker.sv
// -----------------------------------------------------------------------------
// parity_stream_checker
//
// Purpose:
//   Receive-side streaming parity checker. Each valid beat carries a DATA_W-bit
//   word and its parity bit. The block flags per-word parity errors in even or
//   odd mode, aggregates errors over frames delimited by in_last, reports the
//   frame length, and keeps a saturating count of failed beats.
//   All outputs are registered (1-cycle latency).
//
// Parameters:
//   DATA_W    data word width (>= 1)
//   CNT_W     width of err_cnt and of the frame beat counter (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   beat qualifier, no backpressure
//   in_data    in   data word
//   in_par     in   received parity bit
//   in_last    in   final beat of frame (only meaningful with in_valid)
//   mode       in   0 = even parity, 1 = odd parity, judged per beat
//   clr_cnt    in   synchronous clear of err_cnt (wins over a counted error)
//   out_valid  out  registered in_valid
//   out_data   out  registered in_data (holds when no beat)
//   out_last   out  registered in_last & in_valid
//   chk        out  per-word error flag, valid with out_valid
//   frame_err  out  1 on the out_last beat if any beat of that frame failed
//   frame_len  out  beat count of completed frame, saturating, held between
//   err_cnt    out  saturating count of failed beats
// -----------------------------------------------------------------------------
module parity_stream_checker #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_par,
   input  logic              in_last,
   input  logic              mode,
   input  logic              clr_cnt,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              chk,
   output logic              frame_err,
   output logic [CNT_W-1:0]  frame_len,
   output logic [CNT_W-1:0]  err_cnt
);

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_IN_FRAME = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_ferr;
   logic                w_ferr_next;
   logic [CNT_W-1:0]    r_fcnt;
   logic [CNT_W-1:0]    w_fcnt_next;
   logic [CNT_W-1:0]    w_fcnt_inc;

   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_last;
   logic                r_chk;
   logic                r_frame_err;
   logic [CNT_W-1:0]    r_frame_len;
   logic [CNT_W-1:0]    r_err_cnt;

   logic                w_err;
   logic                w_last_beat;

   // Total ones over data+parity must be even (mode=0) or odd (mode=1);
   // folding mode into the XOR gives 1 exactly when that rule is broken.
   assign w_err       = (^in_data) ^ in_par ^ mode;
   assign w_last_beat = in_valid & in_last;

   // Saturating increment of the frame beat counter; also used for the
   // reported length so the closing beat is included.
   assign w_fcnt_inc  = (r_fcnt == {CNT_W{1'b1}}) ? r_fcnt : r_fcnt + 1'b1;

   // Frame tracking next-state logic
   always_comb begin
      w_state_next = r_state;
      w_ferr_next  = r_ferr;
      w_fcnt_next  = r_fcnt;
      if (in_valid) begin
         if (in_last) begin
            w_state_next = S_IDLE;
            w_ferr_next  = 1'b0;
            w_fcnt_next  = '0;
         end else begin
            w_state_next = S_IN_FRAME;
            w_ferr_next  = r_ferr | w_err;
            w_fcnt_next  = w_fcnt_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ferr  <= 1'b0;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_state_next;
         r_ferr  <= w_ferr_next;
         r_fcnt  <= w_fcnt_next;
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_chk       <= 1'b0;
         r_frame_err <= 1'b0;
         r_frame_len <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_out_valid <= in_valid;
         r_out_last  <= w_last_beat;
         r_chk       <= in_valid & w_err;
         r_frame_err <= w_last_beat & (r_ferr | w_err);
         if (in_valid) begin
            r_out_data <= in_data;
         end
         if (w_last_beat) begin
            r_frame_len <= w_fcnt_inc;
         end
         // Clear has priority over counting a coincident error beat
         if (clr_cnt) begin
            r_err_cnt <= '0;
         end else if (in_valid && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign chk       = r_chk;
   assign frame_err = r_frame_err;
   assign frame_len = r_frame_len;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_parity_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_parity_stream_checker
//
// Purpose:
//   Directed self-checking bench for parity_stream_checker (DATA_W=8, CNT_W=4).
//   A table of hand-computed vectors covers per-beat checking in both modes,
//   frame aggregation and back-to-back frames; hand-written sequences cover
//   counter saturation, clear priority and reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_parity_stream_checker;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_par;
   logic              in_last;
   logic              mode;
   logic              clr_cnt;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              chk;
   logic              frame_err;
   logic [CNT_W-1:0]  frame_len;
   logic [CNT_W-1:0]  err_cnt;

   int n_checks;
   int n_fails;

   parity_stream_checker #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_par    (in_par),
      .in_last   (in_last),
      .mode      (mode),
      .clr_cnt   (clr_cnt),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .chk       (chk),
      .frame_err (frame_err),
      .frame_len (frame_len),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic              v;
      logic [DATA_W-1:0] d;
      logic              p;
      logic              l;
      logic              m;
      logic              c;
      logic              ov;
      logic [DATA_W-1:0] od;
      logic              ch;
      logic              ol;
      logic              fe;
      logic [CNT_W-1:0]  fl;
      logic [CNT_W-1:0]  ec;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic v, input logic [DATA_W-1:0] d, input logic p,
                      input logic l, input logic m, input logic c,
                      input logic ov, input logic [DATA_W-1:0] od, input logic ch,
                      input logic ol, input logic fe, input logic [CNT_W-1:0] fl,
                      input logic [CNT_W-1:0] ec);
      vec_t t;
      t.v = v; t.d = d; t.p = p; t.l = l; t.m = m; t.c = c;
      t.ov = ov; t.od = od; t.ch = ch; t.ol = ol; t.fe = fe; t.fl = fl; t.ec = ec;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic p,
                        input logic l, input logic m, input logic c);
      in_valid = v; in_data = d; in_par = p; in_last = l; mode = m; clr_cnt = c;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int idx,
                            input logic ov, input logic [DATA_W-1:0] od, input logic ch,
                            input logic ol, input logic fe, input logic [CNT_W-1:0] fl,
                            input logic [CNT_W-1:0] ec);
      $display("%s %0d: ov=%0b od=%02h chk=%0b ol=%0b fe=%0b fl=%0d ec=%0d",
               tag, idx, out_valid, out_data, chk, out_last, frame_err, frame_len, err_cnt);
      check({tag, ".out_valid"}, idx, 32'(out_valid), 32'(ov));
      check({tag, ".out_data"},  idx, 32'(out_data),  32'(od));
      check({tag, ".chk"},       idx, 32'(chk),       32'(ch));
      check({tag, ".out_last"},  idx, 32'(out_last),  32'(ol));
      check({tag, ".frame_err"}, idx, 32'(frame_err), 32'(fe));
      check({tag, ".frame_len"}, idx, 32'(frame_len), 32'(fl));
      check({tag, ".err_cnt"},   idx, 32'(err_cnt),   32'(ec));
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;

      //   v  data  p  l  m  c   | ov  od    chk ol fe fl ec
      // single-beat frames, even mode
      add(1, 8'hA5, 0, 1, 0, 0,   1, 8'hA5, 0, 1, 0, 1, 0);
      add(1, 8'hA5, 1, 1, 0, 0,   1, 8'hA5, 1, 1, 1, 1, 1);
      // odd mode
      add(1, 8'h01, 0, 1, 1, 0,   1, 8'h01, 0, 1, 0, 1, 1);
      add(1, 8'h01, 1, 1, 1, 0,   1, 8'h01, 1, 1, 1, 1, 2);
      // alternating mode, 0xFF/par=0 -> chk equals mode
      add(1, 8'hFF, 0, 1, 0, 0,   1, 8'hFF, 0, 1, 0, 1, 2);
      add(1, 8'hFF, 0, 1, 1, 0,   1, 8'hFF, 1, 1, 1, 1, 3);
      add(1, 8'hFF, 0, 1, 0, 0,   1, 8'hFF, 0, 1, 0, 1, 3);
      add(1, 8'hFF, 0, 1, 1, 0,   1, 8'hFF, 1, 1, 1, 1, 4);
      // idle cycle, in_last without in_valid ignored, out_data holds
      add(0, 8'h33, 1, 1, 0, 0,   0, 8'hFF, 0, 0, 0, 1, 4);
      // 3-beat frame, error on beat 2
      add(1, 8'h10, 1, 0, 0, 0,   1, 8'h10, 0, 0, 0, 1, 4);
      add(1, 8'h30, 1, 0, 0, 0,   1, 8'h30, 1, 0, 0, 1, 5);
      add(1, 8'h03, 0, 1, 0, 0,   1, 8'h03, 0, 1, 1, 3, 5);
      // back-to-back clean 2-beat frame
      add(1, 8'h07, 1, 0, 0, 0,   1, 8'h07, 0, 0, 0, 3, 5);
      add(1, 8'h0F, 0, 1, 0, 0,   1, 8'h0F, 0, 1, 0, 2, 5);
      // single-beat erroneous frame
      add(1, 8'h80, 0, 1, 0, 0,   1, 8'h80, 1, 1, 1, 1, 6);
      // clear counter on an idle cycle
      add(0, 8'h00, 0, 0, 0, 1,   0, 8'h80, 0, 0, 0, 1, 0);
      // mode change mid-frame: error beat in odd mode, clean last in even mode
      add(1, 8'h01, 1, 0, 1, 0,   1, 8'h01, 1, 0, 0, 1, 1);
      add(1, 8'h01, 1, 1, 0, 0,   1, 8'h01, 0, 1, 1, 2, 1);
      // frame with an idle gap inside it
      add(1, 8'h00, 0, 0, 0, 0,   1, 8'h00, 0, 0, 0, 2, 1);
      add(0, 8'hEE, 1, 0, 0, 0,   0, 8'h00, 0, 0, 0, 2, 1);
      add(1, 8'h00, 1, 1, 0, 0,   1, 8'h00, 1, 1, 1, 2, 2);

      // Reset, with a valid beat presented that must be ignored
      rst_n = 1'b0;
      drive(1, 8'h5A, 1, 1, 0, 0);
      step();
      step();
      check_all("reset", 0, 0, 8'h00, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].v, vecs[i].d, vecs[i].p, vecs[i].l, vecs[i].m, vecs[i].c);
         step();
         check_all("vec", i, vecs[i].ov, vecs[i].od, vecs[i].ch, vecs[i].ol,
                   vecs[i].fe, vecs[i].fl, vecs[i].ec);
      end

      // Saturation: clear, then 20 error beats forming one frame; the 20th is last.
      // err_cnt and frame_len both saturate at 15.
      drive(0, 8'h00, 0, 0, 0, 1);
      step();
      check_all("sat_clr", 0, 0, 8'h00, 0, 0, 0, 2, 0);
      for (int i = 0; i < 20; i++) begin
         drive(1, 8'h00, 1, (i == 19), 0, 0);
         step();
         check_all("sat", i, 1, 8'h00, 1, (i == 19), (i == 19),
                   (i == 19) ? 4'd15 : 4'd2,
                   (i + 1 > 15) ? 4'd15 : 4'(i + 1));
      end
      // Clear coincident with an error beat: clear wins
      drive(1, 8'h01, 0, 1, 0, 1);
      step();
      check_all("clr_win", 0, 1, 8'h01, 1, 1, 1, 1, 0);

      // Reset mid-frame after two error beats
      drive(1, 8'h01, 0, 0, 0, 0);
      step();
      check_all("pre_rst", 0, 1, 8'h01, 1, 0, 0, 1, 1);
      drive(1, 8'h03, 1, 0, 0, 0);
      step();
      check_all("pre_rst", 1, 1, 8'h03, 1, 0, 0, 1, 2);
      rst_n = 1'b0;
      drive(1, 8'h01, 0, 1, 0, 0);
      step();
      check_all("mid_rst", 0, 0, 8'h00, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      drive(1, 8'hA5, 0, 1, 0, 0);
      step();
      check_all("post_rst", 0, 1, 8'hA5, 0, 1, 0, 1, 0);
      drive(0, 8'h00, 0, 0, 0, 0);
      step();
      check_all("post_idle", 0, 0, 8'hA5, 0, 0, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
